// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic N:1 AXI-Stream arbiter with round-robin grant, oversize truncation and drain.
// Define ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module axis_pkt_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_FLITS = 23,
  parameter int CNT_W     = 32
) (
  input  logic                       CLK,
  input  logic                       ARESETN,
  input  logic [NUM_IN*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_IN*DATA_W/8-1:0] s_axis_tkeep,
  input  logic [NUM_IN-1:0]          s_axis_tlast,
  input  logic [NUM_IN-1:0]          s_axis_tvalid,
  output logic [NUM_IN-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [DATA_W/8-1:0]        m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(NUM_IN)-1:0]  grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           pkt_count,
  output logic                       oversize_err
);

  localparam int GW = $clog2(NUM_IN);
  localparam int KW = DATA_W / 8;
  localparam int FW = $clog2(MAX_FLITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [FW-1:0]   flit_cnt_q, flit_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic            oversize_q, oversize_d;

  logic [GW-1:0]   sel_idx;
  logic            sel_found;

  logic [DATA_W-1:0] src_data [NUM_IN];
  logic [KW-1:0]     src_keep [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_slice
      assign src_data[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
      assign src_keep[gi] = s_axis_tkeep[gi*KW +: KW];
    end
  endgenerate

  logic g_valid, g_last, at_max;
  assign g_valid = s_axis_tvalid[grant_q];
  assign g_last  = s_axis_tlast[grant_q];
  assign at_max  = (flit_cnt_q == FW'(MAX_FLITS - 1));

  assign m_axis_tdata = src_data[grant_q];
  assign m_axis_tkeep = src_keep[grant_q];
  assign grant_id     = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign pkt_count    = pkt_cnt_q;
  assign oversize_err = oversize_q;

`ifdef ARB_FIXED_PRIO_EN
  // Descending scan so the lowest-index requester is the last (winning) assignment.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (s_axis_tvalid[k]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(k);
      end
    end
  end
`else
  logic [GW-1:0] ptr_q, ptr_d;
  int unsigned   rr_cand;

  // Scan offsets NUM_IN..1 so the requester nearest after ptr_q wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    rr_cand   = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      rr_cand = 32'(ptr_q) + 32'(k);
      if (rr_cand >= 32'(NUM_IN)) rr_cand = rr_cand - 32'(NUM_IN);
      if (s_axis_tvalid[rr_cand]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(rr_cand);
      end
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    flit_cnt_d    = flit_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    oversize_d    = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d         = ptr_q;
`endif
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        m_axis_tvalid          = g_valid;
        m_axis_tlast           = g_last | at_max;
        s_axis_tready[grant_q] = m_axis_tready;
        if (g_valid && m_axis_tready) begin
          if (g_last || at_max) begin
            pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
            flit_cnt_d = '0;
            oversize_d = ~g_last;
`ifndef ARB_FIXED_PRIO_EN
            ptr_d      = grant_q;
`endif
            state_d    = g_last ? ST_IDLE : ST_DRAIN;
          end else begin
            flit_cnt_d = flit_cnt_q + FW'(1);
          end
        end
      end
      ST_DRAIN: begin
        s_axis_tready[grant_q] = 1'b1;
        if (g_valid && g_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      oversize_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q      <= GW'(NUM_IN - 1);
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      oversize_q <= oversize_d;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomised scoreboard bench for axis_pkt_arbiter; expected beats come from a packet-level
// arbitration model, and a negedge monitor compares every presented m_axis flit.
module tb_axis_pkt_arbiter;
  localparam int NUM_IN    = 4;
  localparam int DATA_W    = 64;
  localparam int MAX_FLITS = 23;
  localparam int CNT_W     = 32;
  localparam int KW        = DATA_W / 8;
  localparam int GW        = $clog2(NUM_IN);

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [KW-1:0]     k;
    logic              l;
  } flit_t;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [KW-1:0]     k;
    logic              l;
    logic [GW-1:0]     g;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       ARESETN;
  logic [NUM_IN*DATA_W-1:0]   s_tdata;
  logic [NUM_IN*KW-1:0]       s_tkeep;
  logic [NUM_IN-1:0]          s_tlast, s_tvalid, s_tready;
  logic [DATA_W-1:0]          m_tdata;
  logic [KW-1:0]              m_tkeep;
  logic                       m_tlast, m_tvalid, m_tready;
  logic [GW-1:0]              grant_id;
  logic                       busy, oversize_err;
  logic [CNT_W-1:0]           pkt_count;

  axis_pkt_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .MAX_FLITS(MAX_FLITS), .CNT_W(CNT_W)) dut (
    .CLK(clk), .ARESETN(ARESETN),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count), .oversize_err(oversize_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  flit_t pq [NUM_IN][$];   // stimulus still to be offered per port
  flit_t mq [NUM_IN][$];   // model copy consumed by build_model
  beat_t sb [$];           // scoreboard of expected m_axis beats

  int exp_pkts = 0, exp_ovf = 0, ovf_seen = 0, mptr = NUM_IN - 1;
  bit mon_en = 1'b0, gap_chk = 1'b0, mon_in_pkt = 1'b0;
  int prev_last = -1, first_cyc = -1, start_cyc = 0;
  int stall_lo = 0, stall_hi = -1;
  bit gap_en_v = 1'b0;
  int bp_mode_v = 0;
  logic [NUM_IN-1:0] in_pkt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_flit(input int p, input logic [DATA_W-1:0] d, input logic [KW-1:0] k, input logic l);
    flit_t f;
    f.d = d; f.k = k; f.l = l;
    pq[p].push_back(f);
    mq[p].push_back(f);
  endfunction

  function automatic void add_pkt(input int p, input int len);
    for (int n = 0; n < len; n++) begin
      if (n == len - 1) push_flit(p, {$urandom, $urandom}, KW'($urandom_range(1, 255)), 1'b1);
      else              push_flit(p, {$urandom, $urandom}, '1, 1'b0);
    end
  endfunction

  // Packet-level model: pick the next requesting port, emit at most MAX_FLITS flits with a
  // forced last on the cap, and drop the remainder of oversize packets.
  function automatic void build_model();
    int g, n;
    bit any;
    flit_t f;
    beat_t b;
    forever begin
      any = 1'b0; g = 0;
`ifdef ARB_FIXED_PRIO_EN
      for (int p = 0; p < NUM_IN; p++) begin
        if (mq[p].size() > 0) begin g = p; any = 1'b1; break; end
      end
`else
      for (int k = 1; k <= NUM_IN; k++) begin
        int p;
        p = (mptr + k) % NUM_IN;
        if (mq[p].size() > 0) begin g = p; any = 1'b1; break; end
      end
`endif
      if (!any) break;
      n = 0;
      do begin
        f = mq[g].pop_front();
        n++;
        if (n <= MAX_FLITS) begin
          b.d = f.d; b.k = f.k; b.l = f.l || (n == MAX_FLITS); b.g = GW'(g);
          sb.push_back(b);
        end
        if (n == MAX_FLITS && !f.l) exp_ovf++;
      end while (!f.l);
      exp_pkts++;
      mptr = g;
    end
  endfunction

  task automatic drive_all();
    flit_t f;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pq[i].size() > 0) begin
        f = pq[i][0];
        s_tdata[i*DATA_W +: DATA_W] = f.d;
        s_tkeep[i*KW +: KW]         = f.k;
        s_tlast[i]                  = f.l;
        s_tvalid[i]                 = (gap_en_v && in_pkt[i]) ? ($urandom_range(3) != 0) : 1'b1;
      end else begin
        s_tdata[i*DATA_W +: DATA_W] = '0;
        s_tkeep[i*KW +: KW]         = '0;
        s_tlast[i]                  = 1'b0;
        s_tvalid[i]                 = 1'b0;
      end
    end
    case (bp_mode_v)
      1:       m_tready = ($urandom_range(9) >= 3);
      2:       m_tready = !(cyc >= stall_lo && cyc <= stall_hi);
      default: m_tready = 1'b1;
    endcase
  endtask

  // Offers all queued flits, honouring handshakes, until everything has drained.
  task automatic run(input int budget, input bit gap_en, input int bp_mode);
    logic [NUM_IN-1:0] hs;
    flit_t f;
    bit all_empty;
    gap_en_v  = gap_en;
    bp_mode_v = bp_mode;
    in_pkt    = '0;
    start_cyc = cyc;
    drive_all();
    for (int t = 0; ; t++) begin
      all_empty = 1'b1;
      for (int i = 0; i < NUM_IN; i++) if (pq[i].size() > 0) all_empty = 1'b0;
      if (all_empty && sb.size() == 0 && !busy) break;
      if (t >= budget) begin
        checks++; errors++;
        $display("FAIL run_timeout: got %0d beats outstanding expected 0", sb.size());
        for (int i = 0; i < NUM_IN; i++) pq[i].delete();
        sb.delete();
        break;
      end
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (hs[i] && pq[i].size() > 0) begin
          f = pq[i].pop_front();
          in_pkt[i] = !f.l;
        end
      end
      drive_all();
    end
    s_tvalid = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pkt_count", pkt_count, exp_pkts);
    chk("oversize_pulses", ovf_seen, exp_ovf);
  endtask

  // Monitor: compares every presented flit (beat or stall) with the scoreboard head.
  initial begin
    beat_t e;
    logic [NUM_IN-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (ARESETN && mon_en) begin
        if (oversize_err) ovf_seen++;
        if (m_tvalid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %h expected no valid", m_tdata);
          end else begin
            e = sb[0];
            exp_rdy = '0;
            if (m_tready) exp_rdy[e.g] = 1'b1;
            chk("beat", {m_tdata, m_tkeep, m_tlast, grant_id, s_tready, busy},
                        {e.d, e.k, e.l, e.g, exp_rdy, 1'b1});
            if (m_tready) begin
              void'(sb.pop_front());
              if (!mon_in_pkt) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (gap_chk && prev_last >= 0) chk("idle_gap", cyc - prev_last, 2);
              end
              mon_in_pkt = !m_tlast;
              if (m_tlast) prev_last = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b1;
    in_pkt = '0;
    repeat (3) @(posedge clk);
    #1 ARESETN = 1'b1;
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_oversize", oversize_err, 0);
    mon_en = 1'b1;

    // Contention from reset: ports 0 and 2, two 2-flit packets each.
    @(posedge clk); #1;
    add_pkt(0, 2); add_pkt(2, 2); add_pkt(0, 2); add_pkt(2, 2);
    build_model();
    gap_chk = 1'b1; prev_last = -1;
    run(200, 1'b0, 0);
    gap_chk = 1'b0;

    // Single packet on port 0.
    @(posedge clk); #1;
    push_flit(0, 64'hc4c0c02ca553e16f, 8'hff, 1'b0);
    push_flit(0, 64'h0000007447c0887a, 8'hff, 1'b0);
    push_flit(0, 64'h0100000100030000, 8'hff, 1'b0);
    push_flit(0, 64'h5073930200000000, 8'h0f, 1'b1);
    build_model();
    first_cyc = -1;
    run(100, 1'b0, 0);
    chk("first_beat_latency", first_cyc - start_cyc, 1);
    chk("single_grant_id", grant_id, 0);
    chk("single_busy_after", busy, 0);

    // Backpressure: 3-cycle stall starting on the third flit.
    @(posedge clk); #1;
    add_pkt(3, 6);
    build_model();
    stall_lo = cyc + 3; stall_hi = cyc + 5;
    run(100, 1'b0, 2);

    // Oversize 25-flit packet on port 1, then a normal packet.
    @(posedge clk); #1;
    add_pkt(1, 25); add_pkt(1, 3);
    build_model();
    run(200, 1'b0, 0);

    // Ports 1 and 3 continuously requesting.
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin add_pkt(1, 2); add_pkt(3, 2); end
    build_model();
    run(300, 1'b0, 0);

    // Randomised rounds with source gaps and sink backpressure.
    for (int round = 0; round < 3; round++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 12; n++) begin
        add_pkt($urandom_range(NUM_IN - 1),
                ($urandom_range(9) == 0) ? $urandom_range(20, 28) : $urandom_range(1, 6));
      end
      build_model();
      run(4000, 1'b1, 1);
    end

    // Leave the pointer on port 2, then abort a port-0 packet with reset.
    @(posedge clk); #1;
    add_pkt(2, 1);
    build_model();
    run(100, 1'b0, 0);
    mon_en = 1'b0;
    @(posedge clk); #1;
    s_tvalid[0] = 1'b1; s_tlast[0] = 1'b0; s_tkeep[KW-1:0] = '1; s_tdata[DATA_W-1:0] = 64'h1111;
    m_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", m_tvalid, 1);
    @(posedge clk); #1;
    s_tdata[DATA_W-1:0] = 64'h2222;
    #2 ARESETN = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s_tready", s_tready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    s_tvalid = '0;
    exp_pkts = 0; mptr = NUM_IN - 1; mon_in_pkt = 1'b0;
    repeat (2) @(posedge clk);
    #1 ARESETN = 1'b1;
    mon_en = 1'b1;
    add_pkt(3, 2); add_pkt(0, 2);
    build_model();
    run(100, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
Packet-atomic N:1 AXI-Stream arbiter that shares the single S_AXIS slave port of the JSON packet parser (pr) between several ingress streams. Grants one requester per packet, round-robin, and never interleaves flits of different packets. Enforces the parser's maximum packet length by truncating and draining oversize packets. Provides grant and packet-count status for the control path.

Parameters:
NUM_IN, 4, number of ingress streams (2..8)
DATA_W, 64, tdata width in bits; tkeep width is DATA_W/8
MAX_FLITS, 23, maximum flits per packet accepted by the parser
CNT_W, 32, width of the packet counter

Ports:
CLK  in  1  clock; all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_IN*DATA_W  ingress data; port i occupies slice [i*DATA_W +: DATA_W]
s_axis_tkeep  in  NUM_IN*DATA_W/8  ingress byte enables, sliced per port
s_axis_tlast  in  NUM_IN  ingress end of packet
s_axis_tvalid  in  NUM_IN  ingress valid
s_axis_tready  out  NUM_IN  ingress ready
m_axis_tdata  out  DATA_W  to parser S_AXIS_tdata
m_axis_tkeep  out  DATA_W/8  to parser S_AXIS_tkeep
m_axis_tlast  out  1  to parser S_AXIS_tlast
m_axis_tvalid  out  1  to parser S_AXIS_tvalid
m_axis_tready  in  1  from parser S_AXIS_tready
grant_id  out  clog2(NUM_IN)  index of the current or most recent grant
busy  out  1  high in STREAM or DRAIN
pkt_count  out  CNT_W  packets completed on m_axis
oversize_err  out  1  one-cycle pulse when a packet is truncated

Behaviour:
- Reset (async assert, sync release): state=IDLE; s_axis_tready=0; m_axis_tvalid=0; grant_id=0; busy=0; pkt_count=0; oversize_err=0; flit counter=0; RR pointer=NUM_IN-1, so port 0 has first priority.
- States: IDLE, STREAM, DRAIN.
- IDLE: all s_axis_tready=0; m_axis_tvalid=0. If any s_axis_tvalid is high, select the first valid port searching upward from pointer+1 with wrap. Register it in grant_id and go to STREAM. Arbitration costs exactly one cycle, so there is one idle cycle between consecutive packets.
- STREAM: the m_axis outputs are combinational from granted port g: tdata, tkeep, tvalid, and tlast.
  - s_axis_tready[g]=m_axis_tready; all other tready=0.
  - A beat is a cycle with m_axis_tvalid and m_axis_tready both high; each beat increments the flit counter.
  - Beat with tlast=1: pkt_count+1 (wraps at 2^CNT_W); pointer=g; counter=0; go to IDLE.
  - Beat where counter==MAX_FLITS-1 and source tlast=0: m_axis_tlast is forced to 1 with tkeep passed through. This completes a packet on m_axis (pkt_count+1) and pulses oversize_err; pointer=g; go to DRAIN.
- DRAIN: m_axis_tvalid=0; s_axis_tready[g]=1; discard flits. On a source beat with tlast=1, go to IDLE. pkt_count does not change.
- Requesters that deassert tvalid mid-packet stall the output; the grant is held. There is no timeout.
- grant_id holds its value in IDLE. busy is combinational from state.
- Valid changes on non-granted ports are ignored until the next IDLE.
- Reset mid-packet aborts the packet immediately. The parser sees a truncated packet with no tlast; recovery is the parser's responsibility.

Optional Feature:
ARB_FIXED_PRIO_EN. When defined, IDLE always grants the lowest-index valid port and the RR pointer is not implemented. When undefined, round-robin as above. All other behaviour is identical.

Test Plan:
- Single packet: port 0 sends 4 flits (0xc4c0c02ca553e16f, 0x0000007447c0887a, 0x0100000100030000, 0x5073930200000000), keep ff/ff/ff/0f, last on flit 4, m_tready=1 -> identical 4 beats on m_axis one cycle after request, grant_id=0, pkt_count=1, busy low after the last beat.
- Contention: ports 0 and 2 each present a 2-flit packet simultaneously from reset, then both present again -> order 0,2,0,2; exactly one idle cycle between packets; no interleaving; pkt_count=4.
- Backpressure: m_tready low for 3 cycles mid-packet -> m_axis outputs stable; s_axis_tready[g]=0 during the stall; no beats lost or duplicated.
- Oversize: port 1 sends 25 flits, MAX_FLITS=23 -> 23 beats out with tlast on beat 23; oversize_err pulses once; 2 flits drained with m_tvalid=0; pkt_count=1; next packet accepted normally.
- Reset mid-packet: ARESETN low during beat 2 of 4 -> m_tvalid and all s_tready go low in the same cycle; pkt_count=0; after release, port 0 is granted first.
- Fixed priority (ARB_FIXED_PRIO_EN): ports 1 and 3 continuously valid -> port 1 wins every arbitration.
